// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the 8-bit datapath
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB for a 19-bit instruction set,
// drives the per-cycle datapath strobes and mux selects, tracks return-stack
// depth, runs the data-memory handshake with a timeout, and reports halt/fault.
//
// Ports:
//   clk, reset (sync, active-low)
//   run_en                  permits a new fetch (looked at in FETCH only)
//   instr[18:0]             instruction-memory output at current PC
//   flag_c, flag_z          datapath C / Z flags
//   mem_ack                 data memory done
//   ir_load                 latch instr into IR
//   pc_write, pc_mux[1:0]   PC update: 00 +1, 01 +1+imm8, 10 abs12, 11 stack top
//   alu_op[2:0], alu_use_carry, alu_in_mux (0 regB, 1 imm8)
//   reg_b_mux               0 IR[7:5], 1 IR[13:11]
//   reg_write_mux[1:0]      00 ALU, 01 shifter, 10 memory
//   reg_write               regfile write strobe
//   select_c/z, write_c/z   flag source (0 ALU, 1 shifter) and update strobes
//   mem_req, mem_write      data memory request / write strobe
//   push, pop               return-stack strobes
//   halted, fault, fault_code[1:0] (01 overflow, 10 underflow, 11 mem timeout)
//   instr_count[15:0]       retired-instruction count
module multicycle_ctrl #(
  parameter int STACK_DEPTH = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic [18:0] instr,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic        mem_ack,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_mux,
  output logic [2:0]  alu_op,
  output logic        alu_use_carry,
  output logic        alu_in_mux,
  output logic        reg_b_mux,
  output logic [1:0]  reg_write_mux,
  output logic        reg_write,
  output logic        select_c,
  output logic        select_z,
  output logic        write_c,
  output logic        write_z,
  output logic        mem_req,
  output logic        mem_write,
  output logic        push,
  output logic        pop,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] instr_count
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
  } state_t;

  state_t        state, state_nx;
  logic [18:12]  ir;          // only the opcode fields steer control
  logic [DW-1:0] depth;
  logic [TW-1:0] tmo;
  logic          fault_set;
  logic [1:0]    fault_set_code;
  logic          halt_set;

  // Operand fields belong to the datapath; fold them so they are consumed.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[11:0];

  // Decode
  logic is_alu, is_imm, is_mem, is_store, is_shift, is_ctl;
  logic is_bz, is_bc, is_jmp, is_call, is_ret, is_halt, is_nop;
  logic br_taken;
  logic [1:0] pc_sel;

  always_comb begin
    is_alu   = (ir[18:17] == 2'b00) || (ir[18:17] == 2'b01);
    is_imm   = (ir[18:17] == 2'b01);
    is_mem   = (ir[18:17] == 2'b10);
    is_store = is_mem && ir[16];
    is_shift = (ir[18:17] == 2'b11) && !ir[16];
    is_ctl   = (ir[18:17] == 2'b11) && ir[16];
    is_bz    = is_ctl && (ir[15:14] == 2'b00);
    is_bc    = is_ctl && (ir[15:14] == 2'b01);
    is_jmp   = is_ctl && (ir[15:14] == 2'b10);
    is_call  = is_ctl && (ir[15:14] == 2'b11) && (ir[13:12] == 2'b00);
    is_ret   = is_ctl && (ir[15:14] == 2'b11) && (ir[13:12] == 2'b01);
    is_halt  = is_ctl && (ir[15:14] == 2'b11) && (ir[13:12] == 2'b10);
    is_nop   = is_ctl && (ir[15:14] == 2'b11) && (ir[13:12] == 2'b11);
    br_taken = (is_bz && flag_z) || (is_bc && flag_c);
    if (br_taken)              pc_sel = 2'b01;
    else if (is_jmp || is_call) pc_sel = 2'b10;
    else if (is_ret)            pc_sel = 2'b11;
    else                        pc_sel = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_FETCH;
      ir          <= '0;
      depth       <= '0;
      tmo         <= '0;
      instr_count <= '0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      halted      <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_load)  ir <= instr[18:12];
      if (pc_write) instr_count <= instr_count + 16'd1;
      if (push)     depth <= depth + 1'b1;
      else if (pop) depth <= depth - 1'b1;
      // Holds zero outside MEM so every MEM entry starts a fresh count.
      if (state == S_MEM) tmo <= tmo + 1'b1;
      else                tmo <= '0;
      if (fault_set) begin
        fault      <= 1'b1;
        fault_code <= fault_set_code;
      end
      if (halt_set) halted <= 1'b1;
    end
  end

  always_comb begin
    state_nx       = state;
    ir_load        = 1'b0;
    pc_write       = 1'b0;
    pc_mux         = 2'b00;
    alu_op         = 3'b000;
    alu_use_carry  = 1'b0;
    alu_in_mux     = 1'b0;
    reg_b_mux      = 1'b0;
    reg_write_mux  = 2'b00;
    reg_write      = 1'b0;
    select_c       = 1'b0;
    select_z       = 1'b0;
    write_c        = 1'b0;
    write_z        = 1'b0;
    mem_req        = 1'b0;
    mem_write      = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    fault_set      = 1'b0;
    fault_set_code = 2'b00;
    halt_set       = 1'b0;

    // Mux selects are held for the whole body of the instruction.
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      pc_mux = pc_sel;
      if (is_alu) begin
        alu_op        = ir[16:14];
        alu_use_carry = (ir[16:14] == 3'b001) || (ir[16:14] == 3'b011);
        alu_in_mux    = is_imm;
      end
      if (is_mem) begin
        alu_op     = 3'b000;   // address = base + imm8
        alu_in_mux = 1'b1;
      end
      reg_b_mux = is_store;
      if (is_shift)    reg_write_mux = 2'b01;
      else if (is_mem) reg_write_mux = 2'b10;
      select_c = is_shift;
      select_z = is_shift;
    end

    case (state)
      S_FETCH: begin
        if (run_en) begin
          ir_load  = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          halt_set = 1'b1;
          state_nx = S_HALTED;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_alu || is_shift) begin
          state_nx = S_WB;
        end else if (is_mem) begin
          state_nx = S_MEM;
        end else if (is_call) begin
          if (depth == DW'(STACK_DEPTH)) begin
            fault_set      = 1'b1;
            fault_set_code = 2'b01;
            state_nx       = S_FAULT;
          end else begin
            push     = 1'b1;
            pc_write = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (is_ret) begin
          if (depth == '0) begin
            fault_set      = 1'b1;
            fault_set_code = 2'b10;
            state_nx       = S_FAULT;
          end else begin
            pop      = 1'b1;
            pc_write = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (is_bz || is_bc || is_jmp || is_nop) begin
          pc_write = 1'b1;
          state_nx = S_FETCH;
        end else begin
          halt_set = 1'b1;     // HALT leaves from DECODE; kept for completeness
          state_nx = S_HALTED;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (is_store) begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
            state_nx  = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (tmo == TW'(MEM_TIMEOUT - 1)) begin
          fault_set      = 1'b1;
          fault_set_code = 2'b11;
          state_nx       = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        write_c   = !is_mem;
        write_z   = !is_mem;
        state_nx  = S_FETCH;
      end
      S_HALTED: state_nx = S_HALTED;
      S_FAULT:  state_nx = S_FAULT;
      default:  state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, run_en, flag_c, flag_z, mem_ack;
  logic [18:0] instr;
  logic        ir_load, pc_write, alu_use_carry, alu_in_mux, reg_b_mux;
  logic [1:0]  pc_mux, reg_write_mux, fault_code;
  logic [2:0]  alu_op;
  logic        reg_write, select_c, select_z, write_c, write_z;
  logic        mem_req, mem_write, push, pop, halted, fault;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.STACK_DEPTH(8), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .instr(instr),
    .flag_c(flag_c), .flag_z(flag_z), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_write(pc_write), .pc_mux(pc_mux),
    .alu_op(alu_op), .alu_use_carry(alu_use_carry), .alu_in_mux(alu_in_mux),
    .reg_b_mux(reg_b_mux), .reg_write_mux(reg_write_mux), .reg_write(reg_write),
    .select_c(select_c), .select_z(select_z), .write_c(write_c), .write_z(write_z),
    .mem_req(mem_req), .mem_write(mem_write), .push(push), .pop(pop),
    .halted(halted), .fault(fault), .fault_code(fault_code),
    .instr_count(instr_count)
  );

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  typedef struct {
    logic [18:0] instr;
    int fc, fz, w;
    int lat, pcm, rw, wcz, mw, mreqs, pu, po;
    int aop, ain, auc, rbm, rwm, sel;
    int flt, code, hlt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [18:0] i, input int fc, fz, w, lat, pcm,
                              rw, wcz, mw, mreqs, pu, po, aop, ain, auc, rbm,
                              rwm, sel, flt, code, hlt);
    vec_t v;
    v.instr = i; v.fc = fc; v.fz = fz; v.w = w; v.lat = lat; v.pcm = pcm;
    v.rw = rw; v.wcz = wcz; v.mw = mw; v.mreqs = mreqs; v.pu = pu; v.po = po;
    v.aop = aop; v.ain = ain; v.auc = auc; v.rbm = rbm; v.rwm = rwm; v.sel = sel;
    v.flt = flt; v.code = code; v.hlt = hlt;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0; run_en = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_count = 0;
  endtask

  // Runs one instruction from FETCH; returns one cycle after completion.
  task automatic run_instr(input vec_t v);
    vec_t e;
    int mreqs = 0, rw = 0, wcz = 0, mw = 0, pu = 0, po = 0;
    int pcm = 0, lat = -1, ild = 0;
    int aop = 0, ain = 0, auc = 0, rbm = 0, rwm = 0, sel = 0;
    bit done = 0;
    exp_q.push_back(v);
    instr = v.instr; flag_c = v.fc[0]; flag_z = v.fz[0]; run_en = 1'b1;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c > 1) run_en = 1'b0;
      mem_ack = 1'b0;
      #1;
      if (mem_req && mreqs == v.w) mem_ack = 1'b1;
      #1;
      if (c == 1) ild = int'(ir_load);
      if (c == 2) begin
        aop = int'(alu_op); ain = int'(alu_in_mux); auc = int'(alu_use_carry);
        rbm = int'(reg_b_mux); rwm = int'(reg_write_mux); sel = int'(select_c & select_z);
      end
      if (mem_req)   mreqs++;
      if (reg_write) rw = 1;
      if (write_c && write_z) wcz = 1;
      if (mem_write) mw = 1;
      if (push)      pu++;
      if (pop)       po++;
      if (pc_write || fault || halted) begin
        done = 1;
        lat  = c;
        pcm  = pc_write ? int'(pc_mux) : 0;
        if (pc_write) exp_count++;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL timeout: instr %h did not complete within 40 cycles", v.instr);
    end
    e = exp_q.pop_front();
    chk("ir_load@1", ild, 1);
    chk("latency", lat, e.lat);
    chk("pc_mux", pcm, e.pcm);
    chk("reg_write", rw, e.rw);
    chk("write_cz", wcz, e.wcz);
    chk("mem_write", mw, e.mw);
    chk("mem_req_cycles", mreqs, e.mreqs);
    chk("push", pu, e.pu);
    chk("pop", po, e.po);
    chk("alu_op", aop, e.aop);
    chk("alu_in_mux", ain, e.ain);
    chk("alu_use_carry", auc, e.auc);
    chk("reg_b_mux", rbm, e.rbm);
    chk("reg_write_mux", rwm, e.rwm);
    chk("select_cz", sel, e.sel);
    chk("fault", int'(fault), e.flt);
    chk("fault_code", int'(fault_code), e.code);
    chk("halted", int'(halted), e.hlt);
    chk("instr_count", int'(instr_count), exp_count);
  endtask

  localparam logic [18:0] I_CALL = {2'b11, 1'b1, 2'b11, 2'b00, 12'h000};
  localparam logic [18:0] I_RET  = {2'b11, 1'b1, 2'b11, 2'b01, 12'h000};
  localparam logic [18:0] I_NOP  = {2'b11, 1'b1, 2'b11, 2'b11, 12'h000};
  localparam logic [18:0] I_LOAD = {2'b10, 1'b0, 16'h0abc};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v_call, v_ovf, v_ret, v_unf;
    //          instr                              fc fz w  lat pcm rw wcz mw mrq pu po aop ain auc rbm rwm sel flt code hlt
    vecs.push_back(mk({2'b00,3'b000,14'h0123},     0, 0, 0, 4,  0,  1, 1,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // ADD
    vecs.push_back(mk({2'b00,3'b001,14'h0040},     1, 0, 0, 4,  0,  1, 1,  0, 0,  0, 0, 1,  0,  1,  0,  0,  0,  0,  0,   0)); // ADC
    vecs.push_back(mk({2'b01,3'b011,14'h00ff},     1, 1, 0, 4,  0,  1, 1,  0, 0,  0, 0, 3,  1,  1,  0,  0,  0,  0,  0,   0)); // I op3
    vecs.push_back(mk({2'b01,3'b010,14'h0011},     0, 0, 0, 4,  0,  1, 1,  0, 0,  0, 0, 2,  1,  0,  0,  0,  0,  0,  0,   0)); // I op2
    vecs.push_back(mk({2'b00,3'b111,14'h3fff},     0, 0, 0, 4,  0,  1, 1,  0, 0,  0, 0, 7,  0,  0,  0,  0,  0,  0,  0,   0)); // R op7
    vecs.push_back(mk({2'b11,1'b0,16'h1234},       0, 0, 0, 4,  0,  1, 1,  0, 0,  0, 0, 0,  0,  0,  0,  1,  1,  0,  0,   0)); // SHIFT
    vecs.push_back(mk(I_LOAD,                      0, 0, 2, 7,  0,  1, 0,  0, 3,  0, 0, 0,  1,  0,  0,  2,  0,  0,  0,   0)); // LOAD w=2
    vecs.push_back(mk(I_LOAD,                      0, 0, 0, 5,  0,  1, 0,  0, 1,  0, 0, 0,  1,  0,  0,  2,  0,  0,  0,   0)); // LOAD w=0
    vecs.push_back(mk({2'b10,1'b1,16'h5555},       0, 0, 0, 4,  0,  0, 0,  1, 1,  0, 0, 0,  1,  0,  1,  2,  0,  0,  0,   0)); // STORE w=0
    vecs.push_back(mk({2'b10,1'b1,16'h0101},       0, 0, 3, 7,  0,  0, 0,  1, 4,  0, 0, 0,  1,  0,  1,  2,  0,  0,  0,   0)); // STORE w=3
    vecs.push_back(mk({2'b11,1'b1,2'b00,6'h0,8'h05}, 0, 1, 0, 3, 1, 0, 0,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // BZ taken
    vecs.push_back(mk({2'b11,1'b1,2'b00,6'h0,8'h05}, 1, 0, 0, 3, 0, 0, 0,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // BZ not
    vecs.push_back(mk({2'b11,1'b1,2'b01,6'h0,8'h7f}, 1, 0, 0, 3, 1, 0, 0,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // BC taken
    vecs.push_back(mk({2'b11,1'b1,2'b01,6'h0,8'h7f}, 0, 1, 0, 3, 0, 0, 0,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // BC not
    vecs.push_back(mk({2'b11,1'b1,2'b10,14'h0123}, 0, 0, 0, 3,  2,  0, 0,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // JMP
    vecs.push_back(mk(I_NOP,                       0, 0, 0, 3,  0,  0, 0,  0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0)); // NOP
    vecs.push_back(mk(I_LOAD,                      0, 0, 99, 19, 0, 0, 0,  0, 15, 0, 0, 0,  1,  0,  0,  2,  0,  1,  3,   0)); // mem timeout
    vecs.push_back(mk({2'b11,1'b1,2'b11,2'b10,12'h0}, 0, 0, 0, 3, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   1)); // HALT

    v_call = mk(I_CALL, 0, 0, 0, 3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_ovf  = mk(I_CALL, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v_ret  = mk(I_RET,  0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_unf  = mk(I_RET,  0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);

    instr = '0; flag_c = 1'b0; flag_z = 1'b0;
    reset = 1'b0; run_en = 1'b0; mem_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ir_load", ir_load, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_fault", fault, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_instr_count", instr_count, 0);
    reset = 1'b1;

    // run_en low: FETCH stays put without strobes
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_ir_load", ir_load, 0);
      @(posedge clk); #1;
    end

    foreach (vecs[i]) begin
      run_instr(vecs[i]);
      if (vecs[i].flt != 0 || vecs[i].hlt != 0) begin
        // absorbing state must persist with no strobes
        repeat (3) @(posedge clk);
        #1;
        chk("absorb_pc_write", pc_write, 0);
        chk("absorb_flags", int'(fault | halted), 1);
        do_reset();
      end
    end

    // Stack overflow: 8 CALLs push, the 9th faults
    do_reset();
    for (int k = 0; k < 8; k++) run_instr(v_call);
    run_instr(v_ovf);
    do_reset();

    // RET at depth 0 underflows
    run_instr(v_unf);
    do_reset();

    // CALL then RET returns depth to 0, so a further RET underflows
    run_instr(v_call);
    run_instr(v_ret);
    run_instr(v_unf);
    do_reset();

    // Reset while a LOAD is waiting in MEM
    run_instr(mk(I_NOP, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    instr = I_LOAD; run_en = 1'b1;
    @(posedge clk); #1; run_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mem_wait_mem_req", mem_req, 1);
    chk("mem_wait_count", instr_count, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; exp_count = 0;
    #1;
    chk("post_rst_mem_req", mem_req, 0);
    chk("post_rst_count", instr_count, 0);
    chk("post_rst_no_load", ir_load, 0);
    run_en = 1'b1; #1;
    chk("post_rst_fetch", ir_load, 1);
    run_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
